// File: rtl/ins_stream_gen.sv
// Instruction stream generator: frames buffered instructions between
// start/stop control words, follows stop with a pipeline-drain gap and
// can send standalone end words between frames.
module ins_stream_gen #(
  parameter int unsigned bus_width = 32,
  parameter int unsigned phases    = 5,
  parameter int unsigned depth     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_req,
  input  logic [16:0]              start_field,
  input  logic                     stop_req,
  input  logic [18:0]              stop_field,
  input  logic                     end_req,
  input  logic [18:0]              end_field,
  input  logic                     ins_valid,
  input  logic [bus_width-1:0]     ins_data,
  output logic                     ins_ready,
  output logic [bus_width-1:0]     ins_out,
  output logic                     wait_for_next_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     illegal_ins,
  output logic [$clog2(depth):0]   fifo_count
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = aw + 1;
  localparam int unsigned dw = $clog2(phases + 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, STOP, DRAIN} state_t;

  state_t               state;
  logic [bus_width-1:0] mem [depth];
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        rd_ptr;
  logic [cw-1:0]        count;
  logic                 stop_latched;
  logic [16:0]          start_q;
  logic [18:0]          stop_q;
  logic [dw-1:0]        drain_cnt;

  logic push_try;
  logic is_ctrl;
  logic push;
  logic pop;
  logic stop_pend;
  logic fifo_empties;

  // Push/pop qualification and the frame-close condition
  always_comb begin
    push_try     = ins_valid && ins_ready;
    is_ctrl      = (ins_data[31:26] == 6'h3F);
    push         = push_try && !is_ctrl;
    pop          = (state == STREAM) && (count != '0);
    stop_pend    = stop_latched || stop_req;
    // Close only when nothing is left after this cycle's pop; a push landing
    // on an already-empty FIFO is left for the next frame.
    fifo_empties = (count == '0) || ((count == cw'(1)) && !push);
  end

  assign ins_ready  = (count != cw'(depth));
  assign fifo_count = count;

  // FIFO storage (no reset needed on the data array)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= ins_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      if (push && !pop)      count <= count + cw'(1);
      else if (!push && pop) count <= count - cw'(1);
    end
  end

  // Framing FSM with registered bus outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      ins_out           <= '0;
      wait_for_next_out <= 1'b1;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      illegal_ins       <= 1'b0;
      stop_latched      <= 1'b0;
      start_q           <= '0;
      stop_q            <= '0;
      drain_cnt         <= '0;
    end else begin
      wait_for_next_out <= 1'b1;
      frame_done        <= 1'b0;
      illegal_ins       <= push_try && is_ctrl;
      case (state)
        IDLE: begin
          if (start_req) begin
            start_q <= start_field;
            busy    <= 1'b1;
            state   <= START;
          end else if (end_req) begin
            ins_out           <= bus_width'({6'h3F, 2'b00, 5'b0, end_field});
            wait_for_next_out <= 1'b0;
          end
        end
        START: begin
          ins_out           <= bus_width'({6'h3F, 2'b10, start_q, 7'b0});
          wait_for_next_out <= 1'b0;
          if (stop_req && !stop_latched) begin
            stop_latched <= 1'b1;
            stop_q       <= stop_field;
          end
          state <= STREAM;
        end
        STREAM: begin
          if (stop_req && !stop_latched) begin
            stop_latched <= 1'b1;
            stop_q       <= stop_field;
          end
          if (pop) begin
            ins_out           <= mem[rd_ptr];
            wait_for_next_out <= 1'b0;
          end
          if (stop_pend && fifo_empties) state <= STOP;
        end
        STOP: begin
          ins_out           <= bus_width'({6'h3F, 2'b11, 5'b0, stop_q});
          wait_for_next_out <= 1'b0;
          drain_cnt         <= dw'(phases);
          state             <= DRAIN;
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state        <= IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b1;
            stop_latched <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - dw'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_stream_gen.sv
// Self-checking bench for ins_stream_gen: queue-based behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ins_stream_gen;

  localparam int BW  = 32;
  localparam int PH  = 5;
  localparam int DEP = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start_req = 1'b0;
  logic [16:0]   start_field = '0;
  logic          stop_req = 1'b0;
  logic [18:0]   stop_field = '0;
  logic          end_req = 1'b0;
  logic [18:0]   end_field = '0;
  logic          ins_valid = 1'b0;
  logic [BW-1:0] ins_data = '0;
  logic          ins_ready;
  logic [BW-1:0] ins_out;
  logic          wait_for_next_out;
  logic          busy;
  logic          frame_done;
  logic          illegal_ins;
  logic [3:0]    fifo_count;

  ins_stream_gen #(.bus_width(BW), .phases(PH), .depth(DEP)) dut (
    .clock(clock), .reset(reset),
    .start_req(start_req), .start_field(start_field),
    .stop_req(stop_req), .stop_field(stop_field),
    .end_req(end_req), .end_field(end_field),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
    .ins_out(ins_out), .wait_for_next_out(wait_for_next_out),
    .busy(busy), .frame_done(frame_done), .illegal_ins(illegal_ins),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl(input logic [1:0] code, input logic [23:0] payload);
    return {6'h3F, code, payload};
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_HEAD, M_BODY, M_TAIL, M_GAP} mphase_t;
  mphase_t     ph = M_IDLE;
  bit [31:0]   q[$];
  bit          armed = 0;
  bit          m_stop = 0;
  logic [16:0] m_startf;
  logic [18:0] m_stopf;
  int          gap_elapsed;
  logic [31:0] e_out;
  logic        e_wait, e_busy, e_done, e_ill;

  always @(posedge clock) begin
    if (reset) begin
      armed = 1; q.delete(); ph = M_IDLE; m_stop = 0;
      e_out = '0; e_wait = 1; e_busy = 0; e_done = 0; e_ill = 0;
    end else begin
      int n;
      bit acc, bad, pushed;
      n      = q.size();
      acc    = ins_valid && (n < DEP);
      bad    = acc && (ins_data[31:26] == 6'h3F);
      pushed = acc && !bad;
      e_wait = 1; e_done = 0; e_ill = bad;
      case (ph)
        M_IDLE:
          if (start_req) begin m_startf = start_field; ph = M_HEAD; end
          else if (end_req) begin e_out = ctrl(2'b00, {5'b0, end_field}); e_wait = 0; end
        M_HEAD: begin
          e_out = ctrl(2'b10, {m_startf, 7'b0}); e_wait = 0;
          if (stop_req && !m_stop) begin m_stop = 1; m_stopf = stop_field; end
          ph = M_BODY;
        end
        M_BODY: begin
          if (stop_req && !m_stop) begin m_stop = 1; m_stopf = stop_field; end
          if (n > 0) begin e_out = q.pop_front(); e_wait = 0; end
          if (m_stop && q.size() == 0 && (n == 0 || !pushed)) ph = M_TAIL;
        end
        M_TAIL: begin
          e_out = ctrl(2'b11, {5'b0, m_stopf}); e_wait = 0;
          gap_elapsed = 0; ph = M_GAP;
        end
        M_GAP:
          if (gap_elapsed == PH) begin ph = M_IDLE; e_done = 1; m_stop = 0; end
          else gap_elapsed++;
        default: ph = M_IDLE;
      endcase
      if (pushed) q.push_back(ins_data);
      e_busy = (ph != M_IDLE);
    end
  end

  // ---------------- compare process + emission log ----------------
  logic [31:0] emitted[$];
  int          gaps[$];
  int          gap_run = 0;
  int          drain_seen = -1;

  always @(negedge clock) begin
    if (armed) begin
      chk("ins_out", ins_out, e_out);
      chk("wait", wait_for_next_out, e_wait);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_done);
      chk("illegal_ins", illegal_ins, e_ill);
      chk("fifo_count", fifo_count, q.size());
      chk("ins_ready", ins_ready, q.size() < DEP);
      if (wait_for_next_out === 1'b0) begin
        emitted.push_back(ins_out); gaps.push_back(gap_run); gap_run = 0;
      end else begin
        if (frame_done === 1'b1) drain_seen = gap_run;
        gap_run++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    logic acc;
    acc = ins_valid && ins_ready;
    @(posedge clock);
    #1;
    if (acc) ins_valid = 0;
    start_req = 0; stop_req = 0; end_req = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    ins_valid = 1; ins_data = w;
    for (int i = 0; i < 40 && ins_valid; i++) step();
    chk("push_accepted", ins_valid, 1'b0);
    ins_valid = 0;
  endtask

  task automatic wait_done(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (frame_done === 1'b1) break;
      step();
    end
    chk(name, frame_done, 1'b1);
    step();
  endtask

  task automatic check_seq(input string name, input logic [31:0] exp[$]);
    chk({name, "_len"}, emitted.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_w%0d", name, i), (i < emitted.size()) ? emitted[i] : 32'hx, exp[i]);
  endtask

  localparam logic [31:0] START_W = 32'hFED5E680; // {3F,10,1ABCD,7'b0}
  localparam logic [31:0] STOP_W  = 32'hFF012345;

  initial begin
    logic [31:0] exp[$];
    // reset
    step(); step(); reset = 0;
    chk("rst_ins_out", ins_out, 32'h0);
    chk("rst_wait", wait_for_next_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 4'd0);

    // T1: preload 3, framed with start/stop, drain gap
    push_word(32'h00000011); push_word(32'h04000022); push_word(32'h80000033);
    emitted.delete(); gaps.delete();
    start_field = 17'h1ABCD; start_req = 1; step();
    stop_field = 19'h12345; stop_req = 1; step();
    wait_done("t1_done", 40);
    exp = '{START_W, 32'h00000011, 32'h04000022, 32'h80000033, STOP_W};
    check_seq("t1", exp);
    chk("t1_drain_gap", drain_seen, PH);
    chk("t1_no_body_gaps", (gaps.size() == 5) ? gaps[1] + gaps[2] + gaps[3] + gaps[4] : -1, 0);

    // T2: empty FIFO in STREAM for 4 cycles, then one push
    emitted.delete(); gaps.delete();
    start_req = 1; step(); step();
    step(); step(); step();
    push_word(32'h12345678);
    stop_req = 1; step();
    wait_done("t2_done", 20);
    exp = '{START_W, 32'h12345678, STOP_W};
    check_seq("t2", exp);
    chk("t2_bubbles", (gaps.size() > 1) ? gaps[1] : -1, 4);

    // T3: overfill, 9th held, then all 9 streamed in order
    for (int i = 0; i < 8; i++) push_word(32'h00001000 + i);
    chk("t3_count_full", fifo_count, 4'd8);
    chk("t3_ready_low", ins_ready, 1'b0);
    ins_valid = 1; ins_data = 32'h00001008;
    step(); step();
    chk("t3_held_count", fifo_count, 4'd8);
    emitted.delete();
    start_req = 1; step();
    stop_req = 1; step();
    wait_done("t3_done", 60);
    exp = '{START_W};
    for (int i = 0; i < 9; i++) exp.push_back(32'h00001000 + i);
    exp.push_back(STOP_W);
    check_seq("t3", exp);

    // T4: aliased control word is rejected
    emitted.delete();
    ins_valid = 1; ins_data = 32'hFC000001; step();
    chk("t4_illegal", illegal_ins, 1'b1);
    chk("t4_count", fifo_count, 4'd0);
    step();
    chk("t4_illegal_pulse", illegal_ins, 1'b0);

    // T5: end word, then start beats end
    end_field = 19'h7; end_req = 1; step();
    chk("t5_end_word", ins_out, 32'hFC000007);
    chk("t5_end_wait", wait_for_next_out, 1'b0);
    step();
    chk("t5_end_once", wait_for_next_out, 1'b1);
    start_req = 1; end_req = 1; step();
    stop_req = 1; step();
    wait_done("t5_done", 20);
    exp = '{32'hFC000007, START_W, STOP_W};
    check_seq("t5", exp);

    // T6: reset mid-STREAM with 2 words buffered
    for (int i = 0; i < 4; i++) push_word(32'h00002000 + i);
    start_req = 1; step(); step(); step(); step();
    chk("t6_pre_count", fifo_count, 4'd2);
    reset = 1; step();
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", fifo_count, 4'd0);
    chk("t6_wait", wait_for_next_out, 1'b1);
    chk("t6_out", ins_out, 32'h0);
    reset = 0; emitted.delete();
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_stop", emitted.size(), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      start_req   = ($urandom_range(0, 19) == 0);
      end_req     = ($urandom_range(0, 19) == 0);
      stop_req    = ($urandom_range(0, 7) == 0);
      start_field = 17'($urandom);
      stop_field  = 19'($urandom);
      end_field   = 19'($urandom);
      ins_valid   = $urandom_range(0, 1) == 1;
      ins_data    = $urandom;
      if ($urandom_range(0, 7) == 0) ins_data[31:26] = 6'h3F;
      step();
    end
    reset = 0; ins_valid = 0;
    for (int i = 0; i < 5; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
